// File: rtl/rand_share_arbiter.sv
// rand_share_arbiter: shares one WIDTH-bit random stream among NUM_REQ
// requesters. Requesters are served round-robin. Each draw is bounded to an
// inclusive per-requester limit by rejection sampling. After MAX_TRIES
// rejected samples, a masked fallback value is delivered instead.
//
// Optional build macro RAND_LFSR_EN: an internal 9-bit LFSR (x^9+x^5+1)
// replaces rnd_in/rnd_valid as the sample source.
module rand_share_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         WIDTH     = 9,
  parameter int         MAX_TRIES = 4,
  parameter logic [8:0] SEED      = 9'h1A5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         rnd_in,
  input  logic                     rnd_valid,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] lim,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         rand_out,
  output logic [2:0]               grant_idx,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAW = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  // The last rejection index at which the fallback path takes over.
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

  logic [1:0]       state;
  logic [2:0]       rr_ptr;
  logic [3:0]       tries;
  logic [7:0]       req_ext;
  logic [WIDTH-1:0] lim_a [8];
  logic [WIDTH-1:0] lim_g;
  logic [WIDTH-1:0] smp;
  logic             smp_vld;
  logic [2:0]       pick;
  logic [2:0]       nxt;
  logic [7:0]       onehot;

  // Pad request and limit vectors to 8 entries.
  // This lets a 3-bit index address them at any NUM_REQ.
  assign req_ext = 8'(req);

  for (genvar i = 0; i < 8; i++) begin : g_lim
    if (i < NUM_REQ) begin : g_on
      assign lim_a[i] = lim[i*WIDTH +: WIDTH];
    end else begin : g_off
      assign lim_a[i] = '0;
    end
  end

  // Live limit of the granted requester.
  // It may change mid-draw; every sample is compared against the current value.
  assign lim_g  = lim_a[grant_idx];
  assign nxt    = (int'(grant_idx) == NUM_REQ - 1) ? 3'd0 : grant_idx + 3'd1;
  assign onehot = 8'd1 << grant_idx;
  assign busy   = (state != IDLE);

`ifdef RAND_LFSR_EN
  localparam logic [8:0] SEED_INIT = (SEED == 9'h000) ? 9'h001 : SEED;

  logic [8:0] lfsr;
  logic       unused_ports;

  if (WIDTH != 9) begin : g_width_chk
    $error("rand_share_arbiter: WIDTH must be 9 when RAND_LFSR_EN is defined");
  end

  // Free-running Fibonacci LFSR; a stuck-at-zero state is kicked back to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            lfsr <= SEED_INIT;
    else if (lfsr == 9'h000) lfsr <= 9'h001;
    else                     lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  end

  assign smp          = WIDTH'(lfsr);
  assign smp_vld      = 1'b1;
  assign unused_ports = ^{rnd_in, rnd_valid};
`else
  localparam logic [8:0] unused_seed = SEED;

  assign smp     = rnd_in;
  assign smp_vld = rnd_valid;
`endif

  // Round-robin pick: the first requester at or after rr_ptr, with wrap.
  // The loop runs downward so that the smallest offset is written last and wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_ext[3'((int'(rr_ptr) + k) % NUM_REQ)])
        pick = 3'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  // Grant / draw / deliver sequencer.
  // ack is a one-cycle strobe raised on entry to ACK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= 3'd0;
      tries     <= 4'd0;
      ack       <= '0;
      rand_out  <= '0;
      grant_idx <= 3'd0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx <= pick;
            tries     <= 4'd0;
            state     <= DRAW;
          end
        end
        DRAW: begin
          if (!req_ext[grant_idx]) begin
            // Requester withdrew; move past it without delivering.
            rr_ptr <= nxt;
            state  <= IDLE;
          end else if (smp_vld) begin
            if (smp <= lim_g) begin
              rand_out <= smp;
              ack      <= onehot[NUM_REQ-1:0];
              state    <= ACK;
            end else if (tries == TRY_LAST) begin
              // Masking by the limit keeps the fallback value in range.
              rand_out <= smp & lim_g;
              ack      <= onehot[NUM_REQ-1:0];
              state    <= ACK;
            end else begin
              tries <= tries + 4'd1;
            end
          end
        end
        ACK: begin
          rr_ptr <= nxt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_share_arbiter.sv
// Self-checking bench for rand_share_arbiter (default build, rnd_in source).
// A transaction-level model predicts the outputs for every cycle.
// Directed cases pin down the model, then a randomized run follows.
module tb_rand_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 9;
  localparam int MT = 4;

  logic           clk       = 1'b0;
  logic           reset_n   = 1'b0;
  logic [W-1:0]   rnd_in    = '0;
  logic           rnd_valid = 1'b0;
  logic [N-1:0]   req       = '0;
  logic [N*W-1:0] lim       = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   rand_out;
  logic [2:0]     grant_idx;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state. phase: 0 = waiting, 1 = drawing, 2 = delivering.
  int m_phase = 0, m_ptr = 0, m_g = 0, m_rej = 0, m_val = 0;

  rand_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_TRIES(MT), .SEED(9'h1A5)) dut (
    .clk(clk), .reset_n(reset_n), .rnd_in(rnd_in), .rnd_valid(rnd_valid),
    .req(req), .lim(lim), .ack(ack), .rand_out(rand_out),
    .grant_idx(grant_idx), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_g = 0; m_rej = 0; m_val = 0;
  endtask

  // Returns the first requester at or after ptr, wrapping around.
  function automatic int first_req(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return ptr;
  endfunction

  // Computes the model state after the next rising edge from the current inputs.
  task automatic model_step();
    int lg;
    case (m_phase)
      0: if (req != 0) begin
           m_g = first_req(m_ptr, req); m_rej = 0; m_phase = 1;
         end
      1: begin
           lg = int'(lim[m_g*W +: W]);
           if (!req[m_g]) begin
             m_ptr = (m_g + 1) % N; m_phase = 0;
           end else if (rnd_valid) begin
             if (int'(rnd_in) <= lg) begin
               m_val = int'(rnd_in); m_phase = 2;
             end else if (m_rej == MT - 1) begin
               m_val = int'(rnd_in) & lg; m_phase = 2;
             end else begin
               m_rej++;
             end
           end
         end
      default: begin
           m_ptr = (m_g + 1) % N; m_phase = 0;
         end
    endcase
  endtask

  // Per-cycle comparison on the falling edge. After comparing, the model advances.
  initial forever begin
    @(negedge clk);
    if (!reset_n) model_reset();
    chk("ack",       32'(ack),       (m_phase == 2) ? (32'd1 << m_g) : 32'd0);
    chk("rand_out",  32'(rand_out),  32'(m_val));
    chk("grant_idx", 32'(grant_idx), 32'(m_g));
    chk("busy",      32'(busy),      32'(m_phase != 0));
    if (reset_n) model_step();
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; rnd_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic set_all_lim(input logic [W-1:0] v);
    for (int i = 0; i < N; i++) lim[i*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] lv;

    tick();
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rand", 32'(rand_out), 0);

    // Single requester, in-range sample: ack two edges after the request.
    do_reset();
    set_all_lim(9'h1FF); req = 4'b0001; rnd_valid = 1'b1; rnd_in = 9'h0AB;
    tick(); chk("t1_busy", 32'(busy), 1);
    tick(); chk("t1_ack", 32'(ack), 32'h1); chk("t1_val", 32'(rand_out), 32'h0AB);
    tick(); req = 4'b0011;
    tick(); chk("t1_ptr", 32'(grant_idx), 1);
    req = '0; tick(); tick(); tick();

    // All requesters held: grants go 0,1,2,3,0, one every three cycles.
    do_reset();
    set_all_lim(9'h1FF); req = 4'b1111; rnd_valid = 1'b1; rnd_in = 9'h055;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k % 3 == 2) chk("t2_rr", 32'(ack), 32'd1 << ((k / 3) % 4));
    end
    req = '0; tick(); tick();

    // Two rejections, then an in-range sample.
    do_reset();
    set_all_lim(9'h1FF); lim[1*W +: W] = 9'h010;
    req = 4'b0010; rnd_valid = 1'b1; rnd_in = 9'h100;
    tick();
    tick(); rnd_in = 9'h011;
    tick(); rnd_in = 9'h00F;
    chk("t3_noack", 32'(ack), 0);
    tick(); chk("t3_ack", 32'(ack), 32'h2); chk("t3_val", 32'(rand_out), 32'h00F);
    req = '0; tick(); tick();

    // Fallback after MT rejected samples: 0x1F3 & 0x00F = 0x003.
    do_reset();
    set_all_lim(9'h1FF); lim[2*W +: W] = 9'h00F;
    req = 4'b0100; rnd_valid = 1'b1; rnd_in = 9'h1F3;
    for (int k = 1; k <= 4; k++) tick();
    chk("t4_noack", 32'(ack), 0);
    tick(); chk("t4_ack", 32'(ack), 32'h4); chk("t4_val", 32'(rand_out), 32'h003);
    req = '0; tick(); tick();

    // Withdrawal during DRAW: no ack, and the next grant goes to 0.
    do_reset();
    set_all_lim(9'h1FF); req = 4'b1000; rnd_valid = 1'b0;
    tick(); chk("t5_g3", 32'(grant_idx), 3); chk("t5_busy", 32'(busy), 1);
    req = 4'b0001;
    tick(); chk("t5_idle", 32'(busy), 0); chk("t5_noack", 32'(ack), 0);
    tick(); chk("t5_g0", 32'(grant_idx), 0);
    rnd_valid = 1'b1; rnd_in = 9'h05A;
    tick(); chk("t5_ack", 32'(ack), 32'h1); chk("t5_val", 32'(rand_out), 32'h05A);
    req = '0; tick(); tick();

    // Asynchronous reset in the middle of a draw.
    req = 4'b0100; rnd_valid = 1'b0;
    tick(); chk("t6_busy", 32'(busy), 1);
    reset_n = 1'b0; #1;
    chk("t6_rack", 32'(ack), 0); chk("t6_rval", 32'(rand_out), 0);
    chk("t6_rgnt", 32'(grant_idx), 0); chk("t6_rbusy", 32'(busy), 0);
    tick(); tick();
    reset_n = 1'b1; req = 4'b1010; rnd_valid = 1'b1; rnd_in = 9'h123;
    tick(); chk("t6_g1", 32'(grant_idx), 1);
    tick(); chk("t6_ack", 32'(ack), 32'h2); chk("t6_val", 32'(rand_out), 32'h123);
    req = '0; tick(); tick();

    // Randomized traffic, including limit boundaries and occasional resets.
    do_reset();
    set_all_lim(9'h1FF);
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req[i]) req[i] = ($urandom_range(3) == 0);
        else if (ack[i]) req[i] = ($urandom_range(3) == 0);
        else if ($urandom_range(15) == 0) req[i] = 1'b0;
      end
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: lv = 9'h000;
          1: lv = 9'h1FF;
          2: lv = 9'($urandom_range(31));
          default: lv = 9'($urandom);
        endcase
        lim[$urandom_range(N-1)*W +: W] = lv;
      end
      rnd_valid = ($urandom_range(3) != 0);
      rnd_in    = 9'($urandom);
      if (!reset_n) reset_n = ($urandom_range(1) == 0);
      else if ($urandom_range(499) == 0) reset_n = 1'b0;
    end
    reset_n = 1'b1; req = '0;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
